// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM states
// and small address/byte-lane helpers used by the controller and the array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;
    // Wide enough for the largest legal wait count (LATENCY-1 <= 14).
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // An access is refused when it is not word aligned or its word index
    // falls beyond the end of storage.
    function automatic logic addr_is_bad(input logic [WORD_W-1:0] addr,
                                         input int                depth);
        logic [WORD_W-1:0] word_idx;
        word_idx = {2'b00, addr[WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= WORD_W'(depth));
    endfunction

    // Replace only the byte lanes selected by be; other lanes keep old data.
    function automatic logic [WORD_W-1:0] byte_merge(input logic [WORD_W-1:0] old_w,
                                                     input logic [WORD_W-1:0] new_w,
                                                     input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage with a synchronous byte-enabled write port and a
// combinational read port. Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Byte-lane write: untouched lanes are rewritten with their old value.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= byte_merge(mem_q[waddr_i], wdata_i, be_i);
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder. A request is accepted in IDLE,
// held for a fixed number of wait cycles, performed against the storage
// array, and its response held until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    // Wait cycles between acceptance and access; legal range 1..15.
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LATENCY - 1);

    // Control state (asynchronously reset).
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    // Held request payload (no reset; only meaningful after an acceptance).
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    // Values captured into the response registers on the access cycle.
    logic              rsp_err_d;
    logic [WORD_W-1:0] rsp_rdata_d;

    logic              accept;
    logic              access_now;
    logic              mem_we;
    logic [AW-1:0]     word_idx;
    logic [WORD_W-1:0] arr_rdata;

    assign accept     = (state_q == IDLE) && req_valid;
    assign access_now = (state_q == WAIT) && (cnt_q == '0);
    assign word_idx   = addr_q[AW+1:2];

    // Decode the held request: error flag, load data, and store strobe.
    always_comb begin
        rsp_err_d   = addr_is_bad(addr_q, DEPTH);
        rsp_rdata_d = '0;
        if (!we_q && !rsp_err_d) begin
            rsp_rdata_d = arr_rdata;
        end
        mem_we = access_now && we_q && !rsp_err_d;
    end

    // Latch the request payload only on acceptance so later req_* activity
    // cannot disturb a transaction in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= WAIT;
                        cnt_q       <= WAIT_INIT;
                        req_ready_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rsp_rdata_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (word_idx),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .raddr_i (word_idx),
        .rdata_o (arr_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus randomized loads/stores
// compared against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_miss;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] poke_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction. hold = cycles rsp_ready stays low once the
    // response is visible; poke drives a stray store request while waiting.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold, input bit poke);
        logic [31:0] idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] seen_rd;
        logic        seen_err;
        int          edges;
        int          waitc;

        idx     = addr >> 2;
        exp_err = (idx >= DEPTH) || (addr % 4 != 0);
        exp_rd  = 32'h0;
        if (!we && !exp_err) exp_rd = ref_mem[idx];
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end

        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (req_ready !== 1'b1) begin
            chk("ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end

        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = $urandom_range(0, 15);
        edges     = 1;

        while (rsp_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, LATENCY + 1);
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", {31'b0, rsp_err}, {31'b0, exp_err});
        seen_rd  = rsp_rdata;
        seen_err = rsp_err;

        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = poke_addr;
                req_wdata = 32'hDEAD_BEEF;
                req_be    = 4'hF;
            end
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, seen_rd);
            chk("hold_err", {31'b0, rsp_err}, {31'b0, seen_err});
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("ready_back", {31'b0, req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(DEPTH, DEPTH + 8)) * 4;
        if (r == 1) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        return 32'($urandom_range(0, DEPTH - 1)) * 4;
    endfunction

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        poke_addr = 32'd8;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Fill storage so the model knows every word.
        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

        // Full-word store then load at word 21.
        txn(1'b1, 32'd84, 32'd7, 4'hF, 0, 1'b0);
        chk("word21", dut.u_array.mem_q[21], 32'd7);
        txn(1'b0, 32'd84, 32'h0, 4'h0, 0, 1'b0);

        // Partial-lane merge.
        txn(1'b1, 32'd0, 32'hAABB_CCDD, 4'hF, 0, 1'b0);
        txn(1'b1, 32'd0, 32'h0000_1100, 4'b0010, 0, 1'b0);
        txn(1'b0, 32'd0, 32'h0, 4'h0, 0, 1'b0);
        chk("merge_word0", dut.u_array.mem_q[0], 32'hAABB_11DD);

        // be=0 store changes nothing; load ignores be.
        txn(1'b1, 32'd4, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
        txn(1'b0, 32'd4, 32'h0, 4'h5, 0, 1'b0);

        // Out-of-range and misaligned accesses, then prove word 1 untouched.
        txn(1'b0, 32'(4 * DEPTH), 32'h0, 4'hF, 0, 1'b0);
        txn(1'b0, 32'd6, 32'h0, 4'hF, 0, 1'b0);
        txn(1'b1, 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 0, 1'b0);
        txn(1'b1, 32'd6, 32'h1234_5678, 4'hF, 0, 1'b0);
        txn(1'b0, 32'd4, 32'h0, 4'hF, 0, 1'b0);

        // Stalled response with a stray request, then check the stray was dropped.
        txn(1'b0, 32'd84, 32'h0, 4'h0, 5, 1'b1);
        txn(1'b0, poke_addr, 32'h0, 4'h0, 0, 1'b0);

        // Reset in the second wait cycle of a store aborts it.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'd40;
        req_wdata = 32'h1234_5678;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst_rsp_rdata", rsp_rdata, 32'd0);
        chk("arst_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_spurious_rsp", {31'b0, rsp_valid}, 32'd0);
        end
        txn(1'b0, 32'd40, 32'h0, 4'h0, 0, 1'b0);

        // Back-to-back random traffic.
        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(0, 1)), rand_addr(), $urandom,
                4'($urandom_range(0, 15)), (i < 10) ? 0 : $urandom_range(0, 2), 1'b0);
        end

        // Read everything back once.
        for (int i = 0; i < DEPTH; i++) txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
